// File: rtl/ext_mem_responder.sv
// Fixed-latency two-channel off-chip memory model answering the HLS master bus; slave responses are ORed in.
// Optional back-pressure input `stall` is compiled in with EXT_MEM_RESP_STALL_EN.
module ext_mem_responder #(
  parameter int CHANNELS    = 2,
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 8,
  parameter int SIZE_W      = 4,
  parameter int DEPTH       = 64,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                       clock,
  input  logic                       reset,
`ifdef EXT_MEM_RESP_STALL_EN
  input  logic                       stall,
`endif
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [CHANNELS-1:0]        Mout_oe_ram,
  input  logic [CHANNELS-1:0]        Mout_we_ram,
  input  logic [CHANNELS*ADDR_W-1:0] Mout_addr_ram,
  input  logic [CHANNELS*DATA_W-1:0] Mout_Wdata_ram,
  input  logic [CHANNELS*SIZE_W-1:0] Mout_data_ram_size,
  input  logic [CHANNELS*DATA_W-1:0] Sout_Rdata_ram,
  input  logic [CHANNELS-1:0]        Sout_DataRdy,
  input  logic                       init_we,
  input  logic [ADDR_W-1:0]          init_addr,
  input  logic [DATA_W-1:0]          init_data,
  output logic [CHANNELS*DATA_W-1:0] M_Rdata_ram,
  output logic [CHANNELS-1:0]        M_DataRdy,
  output logic                       err_both
);
  localparam int MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY) + 1;
  localparam int IDX_W     = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_DELAY - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_DELAY - 1);

  logic hold;
`ifdef EXT_MEM_RESP_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] wr_en;
  logic [CHANNELS-1:0] proto_err;
  logic [IDX_W-1:0]    idx     [CHANNELS];
  logic [DATA_W-1:0]   rd_byte [CHANNELS];
  logic [DATA_W-1:0]   wr_byte [CHANNELS];

  assign proto_err = Mout_oe_ram & Mout_we_ram;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   lo;
    logic [ADDR_W:0]   hi;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mask;
    logic [CNT_W-1:0]  cnt;
    logic [READ_DELAY-2:0][DATA_W-1:0] pipe;
    logic oe;
    logic we;

    assign addr  = Mout_addr_ram[c*ADDR_W +: ADDR_W];
    assign size  = Mout_data_ram_size[c*SIZE_W +: SIZE_W];
    assign wdata = Mout_Wdata_ram[c*DATA_W +: DATA_W];
    assign oe    = Mout_oe_ram[c];
    assign we    = Mout_we_ram[c];

    // One extra bit keeps base_addr+DEPTH from wrapping at the top of the address space.
    assign lo     = {1'b0, base_addr};
    assign hi     = lo + (ADDR_W+1)'(DEPTH);
    assign hit[c] = ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    assign idx[c] = IDX_W'(addr - base_addr);

    always_comb begin
      mask = '0;
      for (int b = 0; b < DATA_W; b++) mask[b] = (b < int'(size));
    end

    assign rd_byte[c] = hit[c] ? mem[idx[c]] : '0;
    assign wr_en[c]   = we && hit[c] && !oe;
    assign wr_byte[c] = (wdata & mask) | (mem[idx[c]] & ~mask);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt  <= '0;
        pipe <= '0;
      end else if (!hold) begin
        if (proto_err[c])
          cnt <= '0;
        else if (oe && hit[c])
          cnt <= (cnt < RD_LAST) ? cnt + 1'b1 : '0;
        else if (we && hit[c])
          cnt <= (cnt < WR_LAST) ? cnt + 1'b1 : '0;
        else
          cnt <= '0;
        pipe[0] <= rd_byte[c];
        for (int s = 1; s < READ_DELAY - 1; s++) pipe[s] <= pipe[s-1];
      end
    end

    assign M_DataRdy[c] = Sout_DataRdy[c] |
                          (hit[c] && !proto_err[c] && !hold &&
                           ((oe && cnt == RD_LAST) || (we && cnt == WR_LAST)));
    assign M_Rdata_ram[c*DATA_W +: DATA_W] = pipe[READ_DELAY-2] | Sout_Rdata_ram[c*DATA_W +: DATA_W];
  end

  // Later assignments win: channel 1 over channel 0, preload over both. Contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en[0]) mem[idx[0]] <= wr_byte[0];
    if (wr_en[1]) mem[idx[1]] <= wr_byte[1];
    if (init_we && (init_addr < ADDR_W'(DEPTH))) mem[IDX_W'(init_addr)] <= init_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_both <= 1'b0;
    else       err_both <= err_both | (|proto_err);
  end
endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench for ext_mem_responder: preload, latency, masking, collisions, protocol error, window edges.
module tb_ext_mem_responder;
  logic        clock = 1'b0;
  logic        reset;
`ifdef EXT_MEM_RESP_STALL_EN
  logic        stall;
`endif
  logic [8:0]  base_addr;
  logic [1:0]  Mout_oe_ram, Mout_we_ram;
  logic [17:0] Mout_addr_ram;
  logic [15:0] Mout_Wdata_ram;
  logic [7:0]  Mout_data_ram_size;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0]  Sout_DataRdy;
  logic        init_we;
  logic [8:0]  init_addr;
  logic [7:0]  init_data;
  logic [15:0] M_Rdata_ram;
  logic [1:0]  M_DataRdy;
  logic        err_both;

  int total = 0;
  int bad   = 0;

  ext_mem_responder dut (
    .clock(clock), .reset(reset),
`ifdef EXT_MEM_RESP_STALL_EN
    .stall(stall),
`endif
    .base_addr(base_addr),
    .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram),
    .Mout_addr_ram(Mout_addr_ram), .Mout_Wdata_ram(Mout_Wdata_ram),
    .Mout_data_ram_size(Mout_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy), .err_both(err_both)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic idle;
    Mout_oe_ram = '0; Mout_we_ram = '0; Mout_addr_ram = '0; Mout_Wdata_ram = '0;
    Mout_data_ram_size = '0; Sout_Rdata_ram = '0; Sout_DataRdy = '0; init_we = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic oe, input logic we, input logic [8:0] addr,
                        input logic [7:0] wdata, input logic [3:0] size);
    Mout_oe_ram[c] = oe;
    Mout_we_ram[c] = we;
    Mout_addr_ram[c*9 +: 9] = addr;
    Mout_Wdata_ram[c*8 +: 8] = wdata;
    Mout_data_ram_size[c*4 +: 4] = size;
  endtask

  task automatic preload(input logic [8:0] a, input logic [7:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    tick();
    init_we = 1'b0;
  endtask

  // Two-cycle read on channel c; checks the ready pattern 0 then 1 and the returned byte.
  task automatic read_chk(input string tag, input int c, input logic [8:0] addr, input logic [7:0] exp);
    set_ch(c, 1'b1, 1'b0, addr, 8'h00, 4'd0);
    #1 check({tag, "_rdy0"}, 32'(M_DataRdy[c]), 32'd0);
    tick();
    check({tag, "_rdy1"}, 32'(M_DataRdy[c]), 32'd1);
    check({tag, "_data"}, 32'(M_Rdata_ram[c*8 +: 8]), 32'(exp));
    idle();
    tick();
  endtask

  initial begin
    reset = 1'b1;
`ifdef EXT_MEM_RESP_STALL_EN
    stall = 1'b0;
`endif
    base_addr = 9'h040; init_addr = '0; init_data = '0;
    idle();
    #3;
    check("rst_rdy", 32'(M_DataRdy), 32'd0);
    check("rst_rdata", 32'(M_Rdata_ram), 32'd0);
    check("rst_err", 32'(err_both), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    preload(9'd5, 8'hA7);
    preload(9'd1, 8'h30);
    preload(9'd8, 8'h55);
    preload(9'd0, 8'h12);

    read_chk("rd45", 0, 9'h045, 8'hA7);

    // Nibble write over 0x30 completes in its first cycle.
    set_ch(1, 1'b0, 1'b1, 9'h041, 8'hFF, 4'd4);
    #1 check("wr41_rdy", 32'(M_DataRdy), 32'b10);
    tick();
    idle();
    tick();
    read_chk("rd41", 1, 9'h041, 8'h3F);

    // Same-index collision: channel 1 wins.
    set_ch(0, 1'b0, 1'b1, 9'h048, 8'h11, 4'd8);
    set_ch(1, 1'b0, 1'b1, 9'h048, 8'h22, 4'd8);
    #1 check("wr48_rdy", 32'(M_DataRdy), 32'b11);
    tick();
    idle();
    tick();
    read_chk("rd48", 0, 9'h048, 8'h22);

    // Size 0 writes nothing.
    set_ch(0, 1'b0, 1'b1, 9'h045, 8'h00, 4'd0);
    tick();
    idle();
    tick();
    read_chk("rd45_sz0", 0, 9'h045, 8'hA7);

    // oe and we together: no ready, no write, sticky error.
    set_ch(0, 1'b1, 1'b1, 9'h045, 8'h00, 4'd8);
    #1 check("both_rdy", 32'(M_DataRdy[0]), 32'd0);
    tick();
    check("both_err", 32'(err_both), 32'd1);
    idle();
    tick();
    check("both_err_held", 32'(err_both), 32'd1);
    read_chk("rd45_both", 0, 9'h045, 8'hA7);
    reset = 1'b1;
    #1 check("err_cleared", 32'(err_both), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Out of window: slave response only, memory untouched.
    set_ch(0, 1'b1, 1'b0, 9'h080, 8'h00, 4'd0);
    Sout_DataRdy = 2'b01; Sout_Rdata_ram = 16'h005C;
    tick();
    check("oow_rdy", 32'(M_DataRdy[0]), 32'd1);
    check("oow_rdata", 32'(M_Rdata_ram[7:0]), 32'h5C);
    idle();
    set_ch(1, 1'b0, 1'b1, 9'h080, 8'hEE, 4'd8);
    #1 check("oow_wr_rdy", 32'(M_DataRdy), 32'd0);
    tick();
    idle();
    tick();
    read_chk("rd40", 0, 9'h040, 8'h12);

    // Window edges: 0x7F is the last byte served, 0x3F is below the window.
    set_ch(0, 1'b0, 1'b1, 9'h07F, 8'h99, 4'd8);
    #1 check("top_wr_rdy", 32'(M_DataRdy[0]), 32'd1);
    tick();
    idle();
    tick();
    read_chk("rd7f", 1, 9'h07F, 8'h99);
    set_ch(0, 1'b0, 1'b1, 9'h03F, 8'h77, 4'd8);
    #1 check("low_wr_rdy", 32'(M_DataRdy[0]), 32'd0);
    tick();
    idle();
    tick();

    // Reset mid-read abandons the access; the reissued read takes the full latency.
    set_ch(0, 1'b1, 1'b0, 9'h045, 8'h00, 4'd0);
    tick();
    reset = 1'b1;
    #1 check("midrst_rdy", 32'(M_DataRdy[0]), 32'd0);
    check("midrst_rdata", 32'(M_Rdata_ram), 32'd0);
    tick();
    reset = 1'b0;
    #1 check("reissue_rdy0", 32'(M_DataRdy[0]), 32'd0);
    tick();
    check("reissue_rdy1", 32'(M_DataRdy[0]), 32'd1);
    check("reissue_data", 32'(M_Rdata_ram[7:0]), 32'hA7);
    idle();
    tick();

`ifdef EXT_MEM_RESP_STALL_EN
    set_ch(0, 1'b1, 1'b0, 9'h045, 8'h00, 4'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_rdy", 32'(M_DataRdy[0]), 32'd0);
      tick();
    end
    stall = 1'b0;
    #1 check("stall_rdy_c0", 32'(M_DataRdy[0]), 32'd0);
    tick();
    check("stall_rdy_c1", 32'(M_DataRdy[0]), 32'd1);
    check("stall_data", 32'(M_Rdata_ram[7:0]), 32'hA7);
    idle();
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ext_mem_responder.md
Name: ext_mem_responder

Overview:
- Synthesizable off-chip memory model that sits directly downstream of the HLS top's two-channel master memory bus (Mout_* outputs).
- Answers reads and writes with fixed, parameterized latency and drives M_Rdata_ram / M_DataRdy back into the top.
- Slave-side responses (Sout_*) are ORed in.
- Replaces the behavioural memory in simulation benches and is usable in FPGA prototyping.

Parameters:
- CHANNELS, 2, number of independent memory ports (fixed at 2 in this revision).
- ADDR_W, 9, address bits per channel.
- DATA_W, 8, data bits per channel (one byte).
- SIZE_W, 4, data-size field bits per channel.
- DEPTH, 64, bytes of storage.
- READ_DELAY, 2, cycles from first oe cycle to DataRdy; must be >= 2.
- WRITE_DELAY, 1, cycles from first we cycle to DataRdy; must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- base_addr  in  ADDR_W  lowest address served; window is [base_addr, base_addr+DEPTH).
- Mout_oe_ram  in  2  per-channel read enable.
- Mout_we_ram  in  2  per-channel write enable.
- Mout_addr_ram  in  2*ADDR_W  channel c address at [c*ADDR_W +: ADDR_W].
- Mout_Wdata_ram  in  2*DATA_W  per-channel write data.
- Mout_data_ram_size  in  2*SIZE_W  per-channel access size in bits.
- Sout_Rdata_ram  in  2*DATA_W  slave read data, ORed into M_Rdata_ram.
- Sout_DataRdy  in  2  slave ready, ORed into M_DataRdy.
- init_we  in  1  preload write strobe.
- init_addr  in  ADDR_W  preload offset (0..DEPTH-1).
- init_data  in  DATA_W  preload byte.
- M_Rdata_ram  out  2*DATA_W  read data to the top.
- M_DataRdy  out  2  per-channel access-complete.
- err_both  out  1  sticky flag: oe and we were high together on some channel.

Behaviour:
- In-window test per channel c: hit[c] = base_addr <= addr_c < base_addr+DEPTH.
  - Compute with ADDR_W+1 bits so the window upper bound does not wrap.
  - Storage index is addr_c - base_addr.
- Latency counter cnt[c] (width ceil(log2(max delay))+1), reset 0, updated on the clock edge:
  - oe[c] && hit[c]: cnt <= (cnt < READ_DELAY-1) ? cnt+1 : 0.
  - else we[c] && hit[c]: cnt <= (cnt < WRITE_DELAY-1) ? cnt+1 : 0.
  - else: cnt <= 0.
- M_DataRdy[c] is combinational:
  - Sout_DataRdy[c] | (hit[c] && ((oe[c] && cnt==READ_DELAY-1) || (we[c] && cnt==WRITE_DELAY-1))).
  - The requester holds oe/we and addr stable until it sees DataRdy, so a read completes in READ_DELAY cycles and a write in WRITE_DELAY cycles.
  - Back-to-back accesses restart from cnt=0.
- Read data path:
  - Combinational lookup: byte at the index if hit[c], else 0.
  - The lookup passes through a READ_DELAY-1 stage register pipeline, reset 0.
  - M_Rdata_ram[c] = pipe_out[c] | Sout_Rdata_ram[c].
- Write path, on each edge where we[c] && hit[c] && !oe[c]:
  - mem[idx] <= (wdata & mask) | (mem[idx] & ~mask).
  - mask = (1<<size)-1 for size < 8; all ones for size >= 8; size 0 writes nothing.
  - The write is performed every cycle we is held, which is idempotent.
- Simultaneous events:
  - Both channels write the same index on the same edge: channel 1 wins.
  - init_we has the highest priority over both channels.
  - Read and write to the same index on the same edge: the read returns the old byte.
- Protocol error: oe[c] && we[c] on any channel, with X/Z treated as 0:
  - err_both <= 1 (sticky until reset).
  - No write on that channel; cnt[c] <= 0; DataRdy[c] from this block is forced 0.
- Out-of-window accesses:
  - Never assert DataRdy from this block and never write.
  - Read data contributes 0, so a slave-mapped access relies on Sout_*.
- Reset, asynchronous and usable mid-operation:
  - Clears cnt, the read pipeline and err_both.
  - M_DataRdy and M_Rdata_ram then reflect only Sout_*.
  - Memory contents are preserved; an access in flight is abandoned and must be reissued.

Optional Feature:
- Macro EXT_MEM_RESP_STALL_EN.
- When defined:
  - Adds input port stall (1 bit).
  - While stall=1, cnt[c] and the read pipeline hold their values, and this block's DataRdy contribution is forced to 0.
  - This models slow memory and back-pressure.
- When undefined: no stall port; latency is exactly READ_DELAY / WRITE_DELAY.

Test Plan:
- Preload init_addr=5, init_data=0xA7; base_addr=0x40; channel 0 oe at addr 0x45 held -> M_DataRdy[0]=1 on the 2nd cycle (cnt=1) with M_Rdata_ram[7:0]=0xA7 in the same cycle.
- Channel 1 we at addr 0x41, data 0xFF, size 4, over old byte 0x30 -> DataRdy[1]=1 in the first cycle; a later read returns 0x3F.
- Both channels write 0x48 on the same edge (ch0 0x11, ch1 0x22, size 8) -> read gives 0x22.
- Channel 0 oe and we both high for one cycle -> err_both=1 and held, no write, DataRdy[0]=0; reset clears err_both to 0.
- Read at addr 0x80, outside the window, with Sout_DataRdy[0]=1 and Sout_Rdata_ram=0x5C -> M_DataRdy[0]=1, M_Rdata_ram[7:0]=0x5C, memory unchanged.
- With EXT_MEM_RESP_STALL_EN: stall=1 for 3 cycles during a held read -> DataRdy delayed by exactly 3 cycles, same data returned.
